// File: rtl/function4x1_pkg.sv
// Shared widths and FSM encodings for the 4-input function self-test engine.
// Constants only, so there is no latency or flow control here.
package function4x1_pkg;

    localparam int VEC_COUNT = 16;
    localparam int IDX_W     = 4;
    localparam int ERR_W     = 5;
    localparam int CNT_W     = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_APPLY  = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_SAMPLE = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

endpackage

// File: rtl/function4x1_checker.sv
// Drives all 16 vectors into a 4-in/1-out function and checks f against TRUTH_TABLE.
// Each vector takes SETTLE_CYCLES+2 cycles; start is ignored while busy (no backpressure).
module function4x1_checker
    import function4x1_pkg::*;
#(
    parameter logic [VEC_COUNT-1:0] TRUTH_TABLE   = 16'h6996,
    parameter int unsigned          SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic             fail_seen
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] settle_cnt;
    logic [IDX_W-1:0] stim;

    logic             accept;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    // A new run may only begin from IDLE or DONE; pulses mid-run are dropped.
    assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign mismatch = (f != TRUTH_TABLE[idx]);
    assign err_nxt  = err_count + ERR_W'(mismatch);

    assign a = stim[3];
    assign b = stim[2];
    assign c = stim[1];
    assign d = stim[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else if (accept) begin
            state          <= ST_APPLY;
            idx            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= '0;
            fail_seen      <= 1'b0;
        end else begin
            case (state)
                ST_APPLY: begin
                    stim       <= idx;
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_nxt;
                        if (!fail_seen) begin
                            first_fail_idx <= idx;
                            fail_seen      <= 1'b1;
                        end
                    end
                    // Last vector: stimulus keeps showing index 15 while in DONE.
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_nxt == '0);
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_APPLY;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    state <= state;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_function4x1_checker.sv
// Directed bench: two checker instances (default settle and settle=1) driving
// selectable function models (XOR, stuck-at, 2-cycle registered XOR).
module tb_function4x1_checker;

    localparam int S_DEF  = 2;
    localparam int S_FAST = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start_s1 = 1'b0;
    int         mode = 0;
    int         mode_s1 = 0;

    logic       a, b, c, d, f, busy, done, pass, fail_seen;
    logic [4:0] err_count;
    logic [3:0] first_fail_idx;

    logic       a1, b1, c1, d1, f1, busy1, done1, pass1, fail_seen1;
    logic [4:0] err_count1;
    logic [3:0] first_fail_idx1;
    logic       r1, r2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign f  = (mode == 0) ? (a ^ b ^ c ^ d) : (mode == 1) ? 1'b0 : 1'b1;
    assign f1 = (mode_s1 == 0) ? (a1 ^ b1 ^ c1 ^ d1) : r2;

    always @(posedge clk) begin
        if (reset) begin
            r1 <= 1'b0;
            r2 <= 1'b0;
        end else begin
            r1 <= a1 ^ b1 ^ c1 ^ d1;
            r2 <= r1;
        end
    end

    function4x1_checker #(.TRUTH_TABLE(16'h6996), .SETTLE_CYCLES(S_DEF)) dut (
        .clk(clk), .reset(reset), .start(start),
        .a(a), .b(b), .c(c), .d(d), .f(f),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .fail_seen(fail_seen)
    );

    function4x1_checker #(.TRUTH_TABLE(16'h6996), .SETTLE_CYCLES(S_FAST)) dut_s1 (
        .clk(clk), .reset(reset), .start(start_s1),
        .a(a1), .b(b1), .c(c1), .d(d1), .f(f1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .first_fail_idx(first_fail_idx1), .fail_seen(fail_seen1)
    );

    initial begin
        if (S_DEF < 1 || S_DEF > 15 || S_FAST < 1 || S_FAST > 15) begin
            $display("FAIL settle_range: SETTLE_CYCLES outside 1..15");
            $fatal(1);
        end
    end

    task automatic pulse_start(input bit sel);
        @(negedge clk);
        if (sel) start_s1 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        start_s1 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? done1 : done) === 1'b1) begin
                cycles = i;
                break;
            end
        end
        n_checks++;
        if (cycles < 0) begin
            $display("FAIL done_timeout: done not seen within %0d cycles", budget);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({a, b, c, d, busy, done, pass, fail_seen} !== 8'h00) begin
            $display("FAIL reset_bits: got %b expected 00000000", {a, b, c, d, busy, done, pass, fail_seen});
            n_fail++;
        end
        n_checks++;
        if (err_count !== 5'd0 || first_fail_idx !== 4'd0) begin
            $display("FAIL reset_counts: err=%0d ffi=%0d expected 0 0", err_count, first_fail_idx);
            n_fail++;
        end
    endtask

    task automatic test_xor_run();
        int bad_stim = 0;
        int bad_busy = 0;
        mode = 0;
        pulse_start(1'b0);
        for (int k = 1; k <= 64; k++) begin
            logic [3:0] exp_v;
            @(posedge clk);
            #1;
            exp_v = 4'((k - 1) / 4);
            if ({a, b, c, d} !== exp_v) begin
                if (bad_stim == 0)
                    $display("FAIL xor_stim: cycle %0d got %b expected %b", k, {a, b, c, d}, exp_v);
                bad_stim++;
            end
            if (busy !== (k < 64) || done !== (k == 64)) begin
                if (bad_busy == 0)
                    $display("FAIL xor_busy_done: cycle %0d busy=%b done=%b", k, busy, done);
                bad_busy++;
            end
        end
        n_checks++;
        if (bad_stim != 0) n_fail++;
        n_checks++;
        if (bad_busy != 0) n_fail++;
        n_checks++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_seen !== 1'b0) begin
            $display("FAIL xor_result: pass=%b err=%0d fs=%b expected 1 0 0", pass, err_count, fail_seen);
            n_fail++;
        end
    endtask

    task automatic check_stuck(input string name, input logic [3:0] exp_ffi);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_count !== 5'd8 ||
            fail_seen !== 1'b1 || first_fail_idx !== exp_ffi) begin
            $display("FAIL %s: done=%b pass=%b err=%0d fs=%b ffi=%0d expected 1 0 8 1 %0d",
                     name, done, pass, err_count, fail_seen, first_fail_idx, exp_ffi);
            n_fail++;
        end
    endtask

    task automatic test_stuck0();
        int cyc;
        mode = 1;
        pulse_start(1'b0);
        wait_done(1'b0, 200, cyc);
        check_stuck("stuck0", 4'd1);
    endtask

    task automatic test_stuck1_rerun();
        int cyc;
        mode = 2;
        pulse_start(1'b0);
        wait_done(1'b0, 200, cyc);
        check_stuck("stuck1", 4'd0);
        pulse_start(1'b0);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_count !== 5'd0 || fail_seen !== 1'b0 || pass !== 1'b0) begin
            $display("FAIL restart_clear: done=%b busy=%b err=%0d fs=%b pass=%b expected 0 1 0 0 0",
                     done, busy, err_count, fail_seen, pass);
            n_fail++;
        end
        wait_done(1'b0, 200, cyc);
        n_checks++;
        if (cyc != 64) begin
            $display("FAIL rerun_latency: got %0d expected 64", cyc);
            n_fail++;
        end
        check_stuck("stuck1_rerun", 4'd0);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        mode = 1;
        pulse_start(1'b0);
        repeat (24) @(posedge clk);
        #1;
        // Vectors 0..5 sampled: stuck-0 mismatches at 1, 2, 4.
        n_checks++;
        if (err_count !== 5'd3 || first_fail_idx !== 4'd1 || busy !== 1'b1) begin
            $display("FAIL partial: err=%0d ffi=%0d busy=%b expected 3 1 1", err_count, first_fail_idx, busy);
            n_fail++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({a, b, c, d, busy, done, pass, fail_seen} !== 8'h00 || err_count !== 5'd0 || first_fail_idx !== 4'd0) begin
            $display("FAIL mid_reset: bits=%b err=%0d ffi=%0d expected all 0",
                     {a, b, c, d, busy, done, pass, fail_seen}, err_count, first_fail_idx);
            n_fail++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL idle_hold: busy=%b done=%b expected 0 0", busy, done);
            n_fail++;
        end
        mode = 0;
        pulse_start(1'b0);
        wait_done(1'b0, 200, cyc);
        n_checks++;
        if (pass !== 1'b1 || err_count !== 5'd0 || cyc != 64) begin
            $display("FAIL post_reset_run: pass=%b err=%0d cycles=%0d expected 1 0 64", pass, err_count, cyc);
            n_fail++;
        end
    endtask

    task automatic test_start_while_busy();
        int first_done = -1;
        mode = 0;
        pulse_start(1'b0);
        for (int k = 1; k <= 70; k++) begin
            start = ((k % 7) == 3) && (k < 60);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1 && first_done < 0) first_done = k;
        end
        n_checks++;
        if (first_done != 64) begin
            $display("FAIL busy_start_latency: got %0d expected 64", first_done);
            n_fail++;
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            $display("FAIL busy_start_result: pass=%b err=%0d expected 1 0", pass, err_count);
            n_fail++;
        end
    endtask

    task automatic test_settle1();
        int cyc;
        mode_s1 = 0;
        pulse_start(1'b1);
        wait_done(1'b1, 200, cyc);
        n_checks++;
        if (cyc != 48) begin
            $display("FAIL settle1_latency: got %0d expected 48", cyc);
            n_fail++;
        end
        n_checks++;
        if (pass1 !== 1'b1 || err_count1 !== 5'd0) begin
            $display("FAIL settle1_xor: pass=%b err=%0d expected 1 0", pass1, err_count1);
            n_fail++;
        end
        mode_s1 = 1;
        pulse_start(1'b1);
        wait_done(1'b1, 200, cyc);
        n_checks++;
        if (pass1 !== 1'b0 || err_count1 === 5'd0 || fail_seen1 !== 1'b1 || first_fail_idx1 !== 4'd1) begin
            $display("FAIL settle1_slow_dut: pass=%b err=%0d fs=%b ffi=%0d expected 0 >0 1 1",
                     pass1, err_count1, fail_seen1, first_fail_idx1);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_xor_run();
        test_stuck0();
        test_stuck1_rerun();
        test_reset_mid_run();
        test_start_while_busy();
        test_settle1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/function4x1_checker.md
Name: function4x1_checker

Overview:
- Synthesizable self-test engine for the 4-input, 1-output combinational function block (a, b, c, d -> f).
- Drives all 16 input vectors in order, waits a programmable settle time per vector, samples f and compares it against a parameterised expected truth table.
- Reports pass/fail, mismatch count and the first failing vector.
- Sits in the lab top level wired directly to the function block's ports, replacing hand-written stimulus.

Parameters:
- TRUTH_TABLE, 16'h6996, expected f for vector index i at bit i; default is 4-input XOR.
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling f; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a full 16-vector run
- a  output  1  stimulus bit, vector index bit 3 (MSB)
- b  output  1  stimulus bit, index bit 2
- c  output  1  stimulus bit, index bit 1
- d  output  1  stimulus bit, index bit 0
- f  input  1  response from function block
- busy  output  1  high from start acceptance until DONE entry
- done  output  1  high in DONE; held until next accepted start or reset
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  5  number of mismatching vectors, 0..16
- first_fail_idx  output  4  index of lowest failing vector; valid when fail_seen
- fail_seen  output  1  set on first mismatch of the run

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high. Reset dominates all other inputs.
- Reset values: all outputs registered and 0. This covers a, b, c, d, busy, done, pass, err_count, first_fail_idx and fail_seen. State resets to IDLE, vector index to 0, settle counter to 0.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: start=1 -> APPLY. On acceptance, clear err_count, fail_seen and first_fail_idx; set idx=0 and busy=1.
- APPLY (1 cycle): register {a,b,c,d} <= idx; clear settle counter -> SETTLE.
- SETTLE: increment counter each cycle; after SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE (1 cycle): compare f with TRUTH_TABLE[idx].
  - On mismatch: err_count++. If fail_seen=0, set first_fail_idx=idx and fail_seen=1.
  - If idx==15 -> DONE. Otherwise idx++ -> APPLY.
- DONE: busy=0, done=1, pass=(err_count==0); stimulus holds vector 15.
  - start=1 -> clear results and done; behave as an IDLE acceptance (-> APPLY, idx=0).
- Timing: each vector takes SETTLE_CYCLES+2 cycles. A full run takes 16*(SETTLE_CYCLES+2) cycles from the start-accepting edge to the edge that sets done (64 cycles at default).
- Boundaries:
  - start while busy: ignored, with no effect on idx or results.
  - idx does not wrap; the run ends after index 15.
  - err_count saturates naturally at 16; 5 bits suffice, so no overflow.
  - Comparison in SAMPLE uses the f value present at that edge only.
  - Reset mid-run: next cycle is IDLE with all outputs 0; partial results are discarded.
  - SETTLE_CYCLES outside 1..15: out of spec; the bench flags it with an elaboration check.

Decomposition:
- Package function4x1_pkg contains:
  - state enum (IDLE, APPLY, SETTLE, SAMPLE, DONE)
  - VEC_COUNT=16
  - IDX_W=4
  - ERR_W=5
  - CNT_W=4
- No sub-module. FSM, index counter, settle counter and result registers form one module (~150–200 lines).
- The function block is instantiated alongside it only at top level and in the bench.

Test Plan:
- XOR DUT, defaults; pulse start -> busy for 64 cycles; then done=1, pass=1, err_count=0, fail_seen=0. a,b,c,d step 0000..1111, each held 4 cycles.
- f stuck at 0, TRUTH_TABLE=16'h6996 -> done with err_count=8, pass=0, fail_seen=1, first_fail_idx=1.
- f stuck at 1 -> err_count=8, first_fail_idx=0. Then pulse start in DONE -> results clear the next cycle and a second identical run gives the same values.
- Assert reset after vector 5 is sampled -> next cycle all outputs 0 and state IDLE. A new start gives a clean full run with pass=1 (XOR DUT).
- Pulse start repeatedly during a run (XOR DUT) -> no restart; done still asserts exactly 64 cycles after the first start.
- SETTLE_CYCLES=1 with XOR DUT -> run completes in 48 cycles, pass=1. A DUT with a 2-cycle registered f fails at this setting, showing err_count>0.
